divisor_secuencial: RTL and testbench

Multicycle restoring divider. It is the inverse counterpart of the combinational sumador/multiply datapath: a 32-bit dividend and a 16-bit divisor produce a 32-bit quotient and a 16-bit remainder. It sits in the MIPS execute stage beside the ALU and serves DIV/DIVU-style image-scaling operations. Operands enter and results leave through valid/ready handshakes.

---
 rtl/divisor_secuencial_pkg.sv | 20 ++
 rtl/divisor_secuencial_if.sv | 36 +++
 rtl/divisor_secuencial_paso.sv | 26 ++
 rtl/divisor_secuencial.sv | 155 +++++++++++++++
 tb/tb_divisor_secuencial.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_secuencial_pkg.sv
// +--------------------------------------------------------------------+
// | divisor_pkg : shared types and constants for divisor_secuencial    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package divisor_pkg;

  localparam int DEF_WIDTH_B = 16;
  localparam int DEF_WIDTH_A = 2 * DEF_WIDTH_B;
  localparam int CNT_WIDTH   = $clog2(DEF_WIDTH_A);

  // Quotient reported when the divisor is zero
  localparam logic [DEF_WIDTH_A-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

endpackage

`default_nettype wire

// File: rtl/divisor_secuencial_if.sv
// +--------------------------------------------------------------------+
// | divisor_secuencial_if : operand/result valid-ready handshakes      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface divisor_secuencial_if
  import divisor_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
);

  logic               start_valid;
  logic               start_ready;
  logic [WIDTH_A-1:0] operA;
  logic [WIDTH_B-1:0] operB;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_A-1:0] quot;
  logic [WIDTH_B-1:0] rem;
  logic               div_zero;

  modport master (
    output start_valid, operA, operB, out_ready,
    input  start_ready, out_valid, quot, rem, div_zero
  );

  modport slave (
    input  start_valid, operA, operB, out_ready,
    output start_ready, out_valid, quot, rem, div_zero
  );

endinterface

`default_nettype wire

// File: rtl/divisor_secuencial_paso.sv
// +--------------------------------------------------------------------+
// | div_paso : one restoring-division step (shift in Q msb, try sub D) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module div_paso #(
  parameter int WIDTH_B = 16
) (
  input  logic [WIDTH_B-1:0] r,
  input  logic               q_msb,
  input  logic [WIDTH_B-1:0] d,
  output logic [WIDTH_B-1:0] r_next,
  output logic               q_bit
);

  // R' needs one extra bit; the restored remainder is always below D
  logic [WIDTH_B:0] r_shift;

  assign r_shift = {r, q_msb};
  assign q_bit   = (r_shift >= {1'b0, d});
  assign r_next  = q_bit ? (r_shift[WIDTH_B-1:0] - d) : r_shift[WIDTH_B-1:0];

endmodule

`default_nettype wire

// File: rtl/divisor_secuencial.sv
// +--------------------------------------------------------------------+
// | divisor_secuencial : multicycle restoring divider, one bit/cycle   |
// | Optional DIVISOR_SIGNED_EN: two's complement operands. Rev 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int WIDTH_B = DEF_WIDTH_B,
  parameter int WIDTH_A = DEF_WIDTH_A
) (
  input  logic                 clk,
  input  logic                 rst_n,
  divisor_secuencial_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH_A);

  if (WIDTH_A != 2 * WIDTH_B) begin : g_width_check
    $error("divisor_secuencial: WIDTH_A must equal 2*WIDTH_B");
  end

  div_state_t         state, state_next;
  logic [WIDTH_A-1:0] q, q_step, a_mag, quot_fix, quot_reg;
  logic [WIDTH_B-1:0] r, r_step, d, b_mag, rem_fix, rem_reg;
  logic [CNT_W-1:0]   cnt;
  logic               q_bit, dz_reg, valid_reg;
  logic               accept, finish, retire, ready, op_zero;

  assign op_zero = (bus.operB == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start_valid) begin
          accept     = 1'b1;
          state_next = op_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // Retiring and accepting in one cycle keeps the divider back-to-back
        ready = bus.out_ready;
        if (bus.out_ready) begin
          retire = 1'b1;
          if (bus.start_valid) begin
            accept     = 1'b1;
            state_next = op_zero ? DONE : BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  div_paso #(.WIDTH_B(WIDTH_B)) u_paso (
    .r      (r),
    .q_msb  (q[WIDTH_A-1]),
    .d      (d),
    .r_next (r_step),
    .q_bit  (q_bit)
  );

  assign q_step = {q[WIDTH_A-2:0], q_bit};

`ifdef DIVISOR_SIGNED_EN
  logic neg_q, neg_r;

  assign a_mag    = bus.operA[WIDTH_A-1] ? ({WIDTH_A{1'b0}} - bus.operA) : bus.operA;
  assign b_mag    = bus.operB[WIDTH_B-1] ? ({WIDTH_B{1'b0}} - bus.operB) : bus.operB;
  assign quot_fix = neg_q ? ({WIDTH_A{1'b0}} - q_step) : q_step;
  assign rem_fix  = neg_r ? ({WIDTH_B{1'b0}} - r_step) : r_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= bus.operA[WIDTH_A-1] ^ bus.operB[WIDTH_B-1];
      neg_r <= bus.operA[WIDTH_A-1];
    end
  end
`else
  assign a_mag    = bus.operA;
  assign b_mag    = bus.operB;
  assign quot_fix = q_step;
  assign rem_fix  = r_step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      r         <= '0;
      d         <= '0;
      cnt       <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dz_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else if (accept) begin
      if (op_zero) begin
        quot_reg  <= {WIDTH_A{1'b1}};
        rem_reg   <= bus.operA[WIDTH_B-1:0];
        dz_reg    <= 1'b1;
        valid_reg <= 1'b1;
      end else begin
        q         <= a_mag;
        r         <= '0;
        d         <= b_mag;
        cnt       <= CNT_W'(WIDTH_A - 1);
        valid_reg <= 1'b0;
      end
    end else if (retire) begin
      valid_reg <= 1'b0;
    end else if (state == BUSY) begin
      q   <= q_step;
      r   <= r_step;
      cnt <= cnt - CNT_W'(1);
      if (finish) begin
        quot_reg  <= quot_fix;
        rem_reg   <= rem_fix;
        dz_reg    <= 1'b0;
        valid_reg <= 1'b1;
      end
    end
  end

  assign bus.start_ready = ready;
  assign bus.out_valid   = valid_reg;
  assign bus.quot        = quot_reg;
  assign bus.rem         = rem_reg;
  assign bus.div_zero    = dz_reg;

endmodule

`default_nettype wire

// File: tb/tb_divisor_secuencial.sv
// +--------------------------------------------------------------------+
// | tb_divisor_secuencial : directed + random checks against a model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_divisor_secuencial;

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  divisor_secuencial_if #(.WIDTH_A(32), .WIDTH_B(16)) bus ();

  divisor_secuencial #(.WIDTH_B(16), .WIDTH_A(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected result from arithmetic on the operands
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t e;
`ifdef DIVISOR_SIGNED_EN
    longint sa, sb, lq, lr;
`endif
    if (b == 16'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a[15:0];
      e.dz = 1'b1;
    end else begin
`ifdef DIVISOR_SIGNED_EN
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      lq   = sa / sb;
      lr   = sa % sb;
      e.q  = lq[31:0];
      e.r  = lr[15:0];
`else
      e.q  = a / {16'd0, b};
      e.r  = 16'(a % {16'd0, b});
`endif
      e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic int lat_of(input logic [15:0] b);
    return (b == 16'd0) ? 1 : 33;
  endfunction

  // Compare process: every cycle a result is presented it must match the model
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("model_quot", bus.quot, exp_q[0].q);
        check("model_rem",  bus.rem,  exp_q[0].r);
        check("model_dz",   bus.div_zero, exp_q[0].dz);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge
  task automatic issue(input logic [31:0] a, input logic [15:0] b);
    int n = 0;
    bus.operA       = a;
    bus.operB       = b;
    bus.start_valid = 1'b1;
    @(negedge clk);
    while (!bus.start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("handshake", bus.start_ready, 1);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    exp_q.push_back(model(a, b));
  endtask

  task automatic wait_valid(input int exp_lat, output logic [31:0] q,
                            output logic [15:0] r, output logic dz);
    int lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    q  = bus.quot;
    r  = bus.rem;
    dz = bus.div_zero;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, a;
    logic [15:0] r, b;
    logic        dz;
    logic        pending;
    int          hold;

    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.operA       = '0;
    bus.operB       = '0;
    bus.out_ready   = 1'b0;
    #12;
    check("rst_ready", bus.start_ready, 1);
    check("rst_valid", bus.out_valid, 0);
    check("rst_quot",  bus.quot, 0);
    check("rst_rem",   bus.rem, 0);
    check("rst_dz",    bus.div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    bus.out_ready = 1'b1;
    issue(32'd100, 16'd7);
    wait_valid(33, q, r, dz);
    check("lit_100_7_q", q, 14);
    check("lit_100_7_r", r, 2);
    check("lit_100_7_dz", dz, 0);
    @(posedge clk);
    #1;
    check("valid_drop", bus.out_valid, 0);
    check("hold_quot", bus.quot, 14);

`ifndef DIVISOR_SIGNED_EN
    issue(32'hFFFF_FFFF, 16'hFFFF);
    wait_valid(33, q, r, dz);
    check("lit_max_q", q, 32'h0001_0001);
    check("lit_max_r", r, 0);
    issue(32'd3, 16'h0010);
    wait_valid(33, q, r, dz);
    check("lit_3_16_q", q, 0);
    check("lit_3_16_r", r, 3);
`endif

    issue(32'd5, 16'd0);
    wait_valid(1, q, r, dz);
    check("lit_dz_q", q, 32'hFFFF_FFFF);
    check("lit_dz_r", r, 5);
    check("lit_dz_flag", dz, 1);

    // Back-pressure, then retire and accept in the same cycle
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    issue(32'd77, 16'd5);
    wait_valid(33, q, r, dz);
    repeat (10) begin
      @(negedge clk);
      check("bp_ready", bus.start_ready, 0);
      check("bp_quot", bus.quot, q);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue(32'd20, 16'd4);
    check("b2b_retire", bus.out_valid, 0);
    wait_valid(33, q, r, dz);
    check("lit_20_4_q", q, 5);
    check("lit_20_4_r", r, 0);

    // Abort in the tenth BUSY cycle
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    issue(32'd1000, 16'd3);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_valid", bus.out_valid, 0);
    check("abort_quot", bus.quot, 0);
    check("abort_rem", bus.rem, 0);
    check("abort_ready", bus.start_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'd1000, 16'd3);
    wait_valid(33, q, r, dz);
    check("lit_1000_3_q", q, 333);
    check("lit_1000_3_r", r, 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

`ifdef DIVISOR_SIGNED_EN
    issue(32'hFFFF_FF9C, 16'd7);
    wait_valid(33, q, r, dz);
    check("lit_neg100_7_q", q, 32'hFFFF_FFF2);
    check("lit_neg100_7_r", r, 16'hFFFE);
    issue(32'h8000_0000, 16'hFFFF);
    wait_valid(33, q, r, dz);
    check("lit_ovf_q", q, 32'h8000_0000);
    check("lit_ovf_r", r, 0);
    check("lit_ovf_dz", dz, 0);
    @(posedge clk);
    #1;
`endif

    // Random operands, back-pressure and back-to-back issue
    bus.out_ready = 1'b0;
    pending = 1'b0;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(1, 31);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'hFFFF;
        2:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      bus.out_ready = pending;
      issue(a, b);
      bus.out_ready = 1'b0;
      wait_valid(lat_of(b), q, r, dz);
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 1) == 0) begin
        pending = 1'b1;
      end else begin
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        pending = 1'b0;
        check("rand_drop", bus.out_valid, 0);
      end
    end

    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
